// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Takes the make/break event levels and scancode from the PS/2 frame
//   receiver, which runs in the ps2_clk domain. Synchronises the events
//   into clk, tracks shift / caps lock / E0-extended state, translates
//   scancode set 2 make codes to ASCII and queues the characters in a
//   FIFO behind a valid/ready handshake.
//
// Ports
//   clk            system clock, at least 8x the PS/2 clock rate
//   reset          synchronous, active-high reset
//   key_down_in    make-event level (ps2_clk domain)
//   key_up_in      break-event level (ps2_clk domain)
//   key_in         scancode, stable while either event level is high
//   ascii_ready    consumer accepts the FIFO head
//   ascii_valid    FIFO not empty
//   ascii_data     FIFO head character (0 while empty)
//   shift_active   left or right shift currently held
//   caps_lock      caps lock toggle state
//   fifo_count     current FIFO occupancy
//   fifo_overflow  sticky: a character was dropped on a full FIFO
module ps2_key_decoder #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_down_in,
    input  logic                          key_up_in,
    input  logic [7:0]                    key_in,
    input  logic                          ascii_ready,
    output logic                          ascii_valid,
    output logic [7:0]                    ascii_data,
    output logic                          shift_active,
    output logic                          caps_lock,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    // Returns {hit, character}. Letters are case-flipped by shift XOR caps;
    // digits only respond to shift.
    function automatic logic [8:0] map_code(input logic [7:0] code,
                                            input logic       shift,
                                            input logic       caps);
        logic [7:0] lc;
        logic [7:0] ch;
        logic       hit;
        lc  = 8'h00;
        ch  = 8'h00;
        hit = 1'b1;
        case (code)
            8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";
            8'h23: lc = "d";  8'h24: lc = "e";  8'h2B: lc = "f";
            8'h34: lc = "g";  8'h33: lc = "h";  8'h43: lc = "i";
            8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
            8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";
            8'h4D: lc = "p";  8'h15: lc = "q";  8'h2D: lc = "r";
            8'h1B: lc = "s";  8'h2C: lc = "t";  8'h3C: lc = "u";
            8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
            8'h35: lc = "y";  8'h1A: lc = "z";
            8'h16: ch = shift ? "!" : "1";
            8'h1E: ch = shift ? "@" : "2";
            8'h26: ch = shift ? "#" : "3";
            8'h25: ch = shift ? "$" : "4";
            8'h2E: ch = shift ? "%" : "5";
            8'h36: ch = shift ? "^" : "6";
            8'h3D: ch = shift ? "&" : "7";
            8'h3E: ch = shift ? "*" : "8";
            8'h46: ch = shift ? "(" : "9";
            8'h45: ch = shift ? ")" : "0";
            8'h29: ch = 8'h20;
            8'h5A: ch = 8'h0D;
            8'h66: ch = 8'h08;
            8'h0D: ch = 8'h09;
            8'h76: ch = 8'h1B;
            default: hit = 1'b0;
        endcase
        if (lc != 8'h00) begin
            ch = (shift ^ caps) ? (lc - 8'h20) : lc;
        end
        return {hit, ch};
    endfunction

    // ------------------------------------------------------------------
    // Event synchronisers and rising-edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] down_sync;
    logic [SYNC_STAGES-1:0] up_sync;
    logic                   down_prev;
    logic                   up_prev;
    logic                   down_rise;
    logic                   up_rise;

    assign down_rise = down_sync[SYNC_STAGES-1] & ~down_prev;
    assign up_rise   = up_sync[SYNC_STAGES-1]   & ~up_prev;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            down_sync <= '0;
            up_sync   <= '0;
            down_prev <= 1'b0;
            up_prev   <= 1'b0;
        end else begin
            down_sync <= {down_sync[SYNC_STAGES-2:0], key_down_in};
            up_sync   <= {up_sync[SYNC_STAGES-2:0], key_up_in};
            down_prev <= down_sync[SYNC_STAGES-1];
            up_prev   <= up_sync[SYNC_STAGES-1];
        end
    end

    // Registered event. key_in is stable while the source level is high,
    // and the level has been high for SYNC_STAGES cycles by now.
    logic       ev_down;
    logic       ev_up;
    logic [7:0] ev_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            ev_down <= 1'b0;
            ev_up   <= 1'b0;
            ev_code <= 8'h00;
        end else begin
            ev_up   <= up_rise;
            ev_down <= down_rise & ~up_rise;   // a simultaneous break wins
            if (down_rise || up_rise) begin
                ev_code <= key_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Modifier tracking and character generation
    // ------------------------------------------------------------------
    logic       lshift, rshift, caps_held, ext;
    logic       lshift_n, rshift_n, caps_lock_n, caps_held_n, ext_n;
    logic       push;
    logic [8:0] mapped;

    assign shift_active = lshift | rshift;
    // Uses modifier state from before this event.
    assign mapped       = map_code(ev_code, shift_active, caps_lock);

    // NOTE: every combinational output is defaulted first so no path
    // through the branches can leave a value held, which would infer a latch.
    always_comb begin
        lshift_n    = lshift;
        rshift_n    = rshift;
        caps_lock_n = caps_lock;
        caps_held_n = caps_held;
        ext_n       = ext;
        push        = 1'b0;
        if (ev_down && ev_code == CODE_EXT) begin
            ext_n = 1'b1;
        end else if ((ev_down || ev_up) && ext) begin
            ext_n = 1'b0;                      // extended key: swallowed whole
        end else if (ev_up) begin
            case (ev_code)
                CODE_LSHIFT: lshift_n    = 1'b0;
                CODE_RSHIFT: rshift_n    = 1'b0;
                CODE_CAPS:   caps_held_n = 1'b0;
                default:     ;
            endcase
        end else if (ev_down) begin
            case (ev_code)
                CODE_LSHIFT: lshift_n = 1'b1;
                CODE_RSHIFT: rshift_n = 1'b1;
                CODE_CAPS: begin
                    // Typematic repeats arrive while caps_held is set.
                    if (!caps_held) begin
                        caps_lock_n = ~caps_lock;
                        caps_held_n = 1'b1;
                    end
                end
                default: push = mapped[8];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            caps_lock <= 1'b0;
            caps_held <= 1'b0;
            ext       <= 1'b0;
        end else begin
            lshift    <= lshift_n;
            rshift    <= rshift_n;
            caps_lock <= caps_lock_n;
            caps_held <= caps_held_n;
            ext       <= ext_n;
        end
    end

    // ------------------------------------------------------------------
    // Character FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          do_push;

    assign full        = (count == CW'(FIFO_DEPTH));
    assign ascii_valid = (count != '0);
    assign pop         = ascii_valid & ascii_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push     = push & (~full | pop);
    assign fifo_count  = count;
    assign ascii_data  = ascii_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(pop);
            if (push && full && !pop) fifo_overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; only entries between the
    // pointers are ever read, and ascii_data is forced to 0 while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= mapped[7:0];
    end

endmodule
